bus_arbiter: RTL and testbench

// - N-initiator round-robin arbiter sitting directly upstream of the near port of a bus bridge.
// - Serialises CPU/DMA/video-style initiators onto one request/ready bus.
// - Returns read data and a ready pulse to the granted initiator only.
// - Works with both registered and combinational bridges: ready may lag request by 0..n cycles.

---
 rtl/bus_arbiter_if.sv | 31 +++
 rtl/bus_arbiter.sv | 107 ++++++++++
 tb/tb_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: initiator request/ready buses plus the bridge near-port signals of bus_arbiter
//   request/rw/address/wdata  initiator k request, direction, address [k*28 +: 28], write data [k*32 +: 32]
//   rdata/ready               initiator k read data [k*32 +: 32] and one-cycle completion pulse
//   bus_*                     single request/ready bus towards the bridge near port
//   timeout                   one-cycle pulse on an aborted transfer
//   modport slave is the arbiter view, modport master the initiator/bridge view
interface bus_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0] request;
  logic [N-1:0] rw;
  logic [N*28-1:0] address;
  logic [N*32-1:0] wdata;
  logic [N*32-1:0] rdata;
  logic [N-1:0] ready;
  logic bus_request;
  logic bus_rw;
  logic [27:0] bus_address;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_ready;
  logic timeout;
  modport slave (
    input request, rw, address, wdata, bus_rdata, bus_ready,
    output rdata, ready, bus_request, bus_rw, bus_address, bus_wdata, timeout
  );
  modport master (
    output request, rw, address, wdata, bus_rdata, bus_ready,
    input rdata, ready, bus_request, bus_rw, bus_address, bus_wdata, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter serialising N initiators onto one request/ready bridge bus
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    bus_arbiter_if.slave: initiator side (request/rw/address/wdata in, rdata/ready out)
//          and bridge side (bus_request/bus_rw/bus_address/bus_wdata out, bus_rdata/bus_ready in), timeout out
//   Optional BUS_ARBITER_TIMEOUT_EN: aborts a transfer after TIMEOUT_CYCLES busy cycles,
//   returning 32'hDEAD_BEEF with a ready pulse and a timeout pulse; otherwise timeout is tied 0.
module bus_arbiter #(
  parameter int NUM_INITIATORS = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  bus_arbiter_if.slave bus
);
  localparam int N = NUM_INITIATORS;
  localparam int W = $clog2(N);
  typedef enum logic [1:0] {IDLE, BUSY, HOLDOFF} state_t;
  state_t state;
  logic [W-1:0] grant, last_grant, pick, idx;
  logic [N-1:0][27:0] address;
  logic [N-1:0][31:0] wdata;
  logic [N-1:0][31:0] rdata_q;
  logic [N-1:0] ready_q;
  logic bus_request_q, bus_rw_q;
  logic [27:0] bus_address_q;
  logic [31:0] bus_wdata_q;
  assign address = bus.address;
  assign wdata = bus.wdata;
  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.bus_request = bus_request_q;
  assign bus.bus_rw = bus_rw_q;
  assign bus.bus_address = bus_address_q;
  assign bus.bus_wdata = bus_wdata_q;
  // Scan downwards so the requester closest after last_grant is the one left in pick.
  always_comb begin
    pick = last_grant;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(last_grant) + i) % N);
      if (bus.request[idx]) pick = idx;
    end
  end
`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [15:0] count;
  logic timeout_q;
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= W'(N - 1);
      bus_request_q <= 1'b0;
      bus_rw_q <= 1'b0;
      bus_address_q <= '0;
      bus_wdata_q <= '0;
      ready_q <= '0;
      rdata_q <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      count <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: if (|bus.request) begin
          grant <= pick;
          last_grant <= pick;
          bus_rw_q <= bus.rw[pick];
          bus_address_q <= address[pick];
          bus_wdata_q <= wdata[pick];
          bus_request_q <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
          count <= '0;
`endif
          state <= BUSY;
        end
        // A ready arriving on the expiry edge still completes normally.
        BUSY: if (bus.bus_ready) begin
          bus_request_q <= 1'b0;
          rdata_q[grant] <= bus.bus_rdata;
          ready_q[grant] <= 1'b1;
          state <= HOLDOFF;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (count == 16'(TIMEOUT_CYCLES - 1)) begin
          bus_request_q <= 1'b0;
          rdata_q[grant] <= 32'hDEAD_BEEF;
          ready_q[grant] <= 1'b1;
          timeout_q <= 1'b1;
          state <= HOLDOFF;
        end else count <= count + 16'd1;
`endif
        // One dead cycle swallows the trailing ready of a registered bridge.
        HOLDOFF: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized and directed stimulus for bus_arbiter checked against a transaction-level model
module tb_bus_arbiter;
  localparam int N = 3;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  logic clk, rst_n;
  bus_arbiter_if #(.N(N)) bif ();
  bus_arbiter #(.NUM_INITIATORS(N), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  logic [N-1:0] req_r, rw_r;
  logic [N-1:0][27:0] addr_r;
  logic [N-1:0][31:0] wdata_r;
  logic bready, bprev;
  logic [31:0] brdata, fixed_rd;
  assign bif.request = req_r;
  assign bif.rw = rw_r;
  assign bif.address = addr_r;
  assign bif.wdata = wdata_r;
  assign bif.bus_ready = bready;
  assign bif.bus_rdata = brdata;
  int compared = 0, mismatched = 0;
  int cyc = 0, imode = 0, bmode = 0, fixed_lat = 2, bcnt = 0, blat = 0;
  bit noise = 0, fixed_rd_en = 0;
  bit m_busy = 0;
  int m_ptr = N - 1, m_g = 0, m_start = 0, m_free = 0;
  logic m_rw;
  logic [27:0] m_a, last_rise_addr;
  logic [31:0] m_w;
  logic [31:0] m_rd[N];
  int pulses[N];
  int tcount = 0;
  bit fair_on = 0;
  int fair_n = 0, fair_last = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  // Inputs seen here are the ones sampled at the posedge just passed; outputs are post-edge.
  task automatic model_check();
    logic [N-1:0] er;
    logic et;
    bit rise, found;
    er = '0;
    et = 1'b0;
    rise = 0;
    found = 0;
    if (!rst_n) begin
      m_busy = 0;
      m_ptr = N - 1;
      m_free = cyc + 1;
      for (int k = 0; k < N; k++) m_rd[k] = '0;
    end else if (m_busy) begin
      if (bready) begin
        m_busy = 0;
        er[m_g] = 1'b1;
        m_rd[m_g] = brdata;
        m_free = cyc + 2;
      end
`ifdef BUS_ARBITER_TIMEOUT_EN
      else if (cyc - m_start == TO) begin
        m_busy = 0;
        er[m_g] = 1'b1;
        m_rd[m_g] = 32'hDEAD_BEEF;
        et = 1'b1;
        m_free = cyc + 2;
      end
`endif
    end else if (cyc >= m_free && req_r != '0) begin
      for (int d = 1; d <= N; d++)
        if (!found && req_r[(m_ptr + d) % N]) begin
          found = 1;
          m_g = (m_ptr + d) % N;
        end
      m_ptr = m_g;
      m_busy = 1;
      m_start = cyc;
      m_rw = rw_r[m_g];
      m_a = addr_r[m_g];
      m_w = wdata_r[m_g];
      rise = 1;
    end
    chk("bus_request", 64'(bif.bus_request), 64'(m_busy));
    chk("ready", 64'(bif.ready), 64'(er));
    chk("timeout", 64'(bif.timeout), 64'(et));
    for (int k = 0; k < N; k++) chk($sformatf("rdata%0d", k), 64'(bif.rdata[k*32 +: 32]), 64'(m_rd[k]));
    if (m_busy) begin
      chk("bus_rw", 64'(bif.bus_rw), 64'(m_rw));
      chk("bus_address", 64'(bif.bus_address), 64'(m_a));
      chk("bus_wdata", 64'(bif.bus_wdata), 64'(m_w));
    end
    for (int k = 0; k < N; k++) pulses[k] += int'(bif.ready[k]);
    tcount += int'(bif.timeout);
    if (rise) begin
      last_rise_addr = bif.bus_address;
      if (fair_on) begin
        chk("fair_order", 64'(bif.bus_address), 64'((fair_n % N + 1) * 256));
        if (fair_n > 0) chk("fair_period", 64'(cyc - fair_last), 64'd4);
        fair_last = cyc;
        fair_n++;
      end
    end
  endtask
  task automatic drive();
    for (int k = 0; k < N; k++)
      if (req_r[k] && bif.ready[k]) req_r[k] = 1'b0;
      else if (!req_r[k] && (imode == 2 || (imode == 1 && $urandom_range(0, 3) == 0))) begin
        req_r[k] = 1'b1;
        rw_r[k] = 1'($urandom);
        addr_r[k] = imode == 2 ? 28'((k + 1) * 256) : 28'($urandom);
        wdata_r[k] = $urandom;
      end
    if (bmode == 1) begin
      bready = bprev;
      bprev = bif.bus_request;
      brdata = $urandom;
    end else if (bmode == 2) bready = 1'b0;
    else if (!bif.bus_request) begin
      bready = noise && ($urandom_range(0, 7) == 0);
      bcnt = 0;
      blat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
      brdata = $urandom;
    end else if (!bready) begin
      if (bcnt >= blat) begin
        bready = 1'b1;
        brdata = fixed_rd_en ? fixed_rd : $urandom;
      end else bcnt++;
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    model_check();
    drive();
  endtask
  task automatic issue(input int k, input logic rw, input logic [27:0] a, input logic [31:0] w);
    req_r[k] = 1'b1;
    rw_r[k] = rw;
    addr_r[k] = a;
    wdata_r[k] = w;
  endtask
  task automatic wait_done(input int k, input int lim);
    int n = 0;
    while (req_r[k] && n < lim) begin
      step();
      n++;
    end
    chk("done_wait", 64'(req_r[k]), 64'd0);
  endtask
  task automatic quiesce();
    int n = 0;
    imode = 0;
    while ((req_r != '0 || m_busy) && n < 200) begin
      step();
      n++;
    end
    chk("quiesce", 64'(req_r), 64'd0);
    repeat (3) step();
  endtask
  task automatic clear_pulses();
    for (int k = 0; k < N; k++) pulses[k] = 0;
    tcount = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=stuck expected=finish", cyc);
    $fatal(1);
  end
  initial begin
    int n;
    rst_n = 1'b0;
    req_r = '0;
    rw_r = '0;
    addr_r = '0;
    wdata_r = '0;
    bready = 1'b0;
    bprev = 1'b0;
    brdata = '0;
    fixed_rd = '0;
    clear_pulses();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    fixed_rd_en = 1;
    fixed_rd = 32'h1234_5678;
    issue(0, 1'b0, 28'h000_0100, 32'h0);
    wait_done(0, 20);
    step();
    chk("read_rdata0", 64'(bif.rdata[31:0]), 64'h1234_5678);
    chk("read_pulses0", 64'(pulses[0]), 64'd1);
    chk("read_pulses1", 64'(pulses[1]), 64'd0);
    fixed_rd_en = 0;
    fixed_lat = 3;
    clear_pulses();
    issue(1, 1'b1, 28'h0AB_CDEF, 32'hCAFE_F00D);
    wait_done(1, 20);
    step();
    chk("write_pulses1", 64'(pulses[1]), 64'd1);
    chk("write_pulses0", 64'(pulses[0]), 64'd0);
    quiesce();
    imode = 2;
    bmode = 1;
    bprev = 1'b0;
    fair_on = 1;
    fair_n = 0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    n = 0;
    while (fair_n < 4 * N && n < 200) begin
      step();
      n++;
    end
    fair_on = 0;
    chk("fair_grants", 64'(fair_n), 64'(4 * N));
    quiesce();
    imode = 1;
    repeat (400) step();
    quiesce();
    bmode = 0;
    fixed_lat = 5;
    clear_pulses();
    issue(2, 1'b0, 28'h000_0333, 32'h0);
    n = 0;
    while (!m_busy && n < 20) begin
      step();
      n++;
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_r = '0;
    repeat (3) step();
    chk("rst_no_ready2", 64'(pulses[2]), 64'd0);
    fixed_lat = 1;
    issue(0, 1'b0, 28'h000_0111, 32'h0);
    issue(1, 1'b0, 28'h000_0222, 32'h0);
    last_rise_addr = '0;
    n = 0;
    while (!m_busy && n < 20) begin
      step();
      n++;
    end
    chk("rst_first_grant", 64'(last_rise_addr), 64'h111);
    quiesce();
    fixed_lat = -1;
    noise = 1;
    imode = 1;
    repeat (1500) step();
    quiesce();
    noise = 0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    bmode = 2;
    clear_pulses();
    issue(1, 1'b0, 28'h000_0444, 32'h0);
    wait_done(1, TO + 30);
    step();
    chk("timeout_pulses", 64'(tcount), 64'd1);
    chk("timeout_rdata1", 64'(bif.rdata[63:32]), 64'hDEAD_BEEF);
    bmode = 0;
    quiesce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
